// File: rtl/icache_line_fill.sv
// icache line fill: fetches one line as a beat burst, assembles it, writes it
// to the data array in one full-mask cycle and forwards the missed word early.
//
// Ports:
//   clk0, rst0_n          clock, async active-low reset
//   fill_req, fill_addr   miss request and byte address (sampled in IDLE)
//   fill_busy, fill_done  not-idle flag, one-cycle pulse in the write cycle
//   crit_valid, crit_word registered critical-word forward
//   pmem_*                burst read to memory (line-aligned address, beats)
//   array_*               single full-line write into the data array
module icache_line_fill #(
    parameter int s_index    = 4,
    parameter int s_offset   = 5,
    parameter int beat_width = 64
) (
    input  logic                         clk0,
    input  logic                         rst0_n,
    input  logic                         fill_req,
    input  logic [31:0]                  fill_addr,
    output logic                         fill_busy,
    output logic                         fill_done,
    output logic                         crit_valid,
    output logic [31:0]                  crit_word,
    output logic                         pmem_read,
    output logic [31:0]                  pmem_address,
    input  logic [beat_width-1:0]        pmem_rdata,
    input  logic                         pmem_resp,
    output logic [2**s_offset-1:0]       array_wmask,
    output logic [s_index-1:0]           array_addr,
    output logic [8*(2**s_offset)-1:0]   array_din
);

    localparam int line_width = 8 * (2**s_offset);
    localparam int beats      = line_width / beat_width;
    localparam int cnt_w      = $clog2(beats);
    localparam int beat_lsb   = $clog2(beat_width / 8);
    localparam int wsel_w     = $clog2(beat_width / 32);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        WRITE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [cnt_w-1:0]        cnt_q;
    logic [31:0]             line_addr_q;
    logic [cnt_w-1:0]        crit_beat_q;
    logic [wsel_w-1:0]       crit_wsel_q;
    logic [line_width-1:0]   buf_q;
    logic                    beat_take;
    logic                    last_beat;
    logic                    unused_addr;

    // Bits below the word select never matter for an instruction fetch.
    assign unused_addr = &{1'b0, fill_addr[1:0]};

    assign beat_take = (state_q == BURST) && pmem_resp;
    assign last_beat = beat_take && (cnt_q == cnt_w'(beats - 1));

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_busy    = 1'b0;
        fill_done    = 1'b0;
        pmem_read    = 1'b0;
        pmem_address = '0;
        array_wmask  = '0;
        array_addr   = '0;
        array_din    = '0;
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                fill_busy    = 1'b1;
                pmem_read    = 1'b1;
                pmem_address = line_addr_q;
                if (last_beat) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                fill_busy   = 1'b1;
                fill_done   = 1'b1;
                array_wmask = '1;
                array_addr  = line_addr_q[s_offset +: s_index];
                array_din   = buf_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            cnt_q       <= '0;
            line_addr_q <= '0;
            crit_beat_q <= '0;
            crit_wsel_q <= '0;
            buf_q       <= '0;
            crit_valid  <= 1'b0;
            crit_word   <= '0;
        end else begin
            crit_valid <= 1'b0;
            if (state_q == IDLE && fill_req) begin
                line_addr_q <= {fill_addr[31:s_offset], {s_offset{1'b0}}};
                cnt_q       <= '0;
                crit_beat_q <= fill_addr[s_offset-1 -: cnt_w];
                crit_wsel_q <= fill_addr[beat_lsb-1 -: wsel_w];
            end
            if (beat_take) begin
                buf_q[cnt_q*beat_width +: beat_width] <= pmem_rdata;
                cnt_q <= cnt_q + 1'b1;
                // Forward the missed word the cycle after its beat lands.
                if (cnt_q == crit_beat_q) begin
                    crit_valid <= 1'b1;
                    crit_word  <= pmem_rdata[crit_wsel_q*32 +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// Testbench for icache_line_fill: directed scenarios plus randomized fills,
// each checked against a line/critical-word model built from beat lists.
module tb_icache_line_fill;

    logic         clk0;
    logic         rst0_n;
    logic         fill_req;
    logic [31:0]  fill_addr;
    logic         fill_busy;
    logic         fill_done;
    logic         crit_valid;
    logic [31:0]  crit_word;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  array_wmask;
    logic [3:0]   array_addr;
    logic [255:0] array_din;

    int n_cmp = 0;
    int n_err = 0;

    icache_line_fill dut (
        .clk0(clk0),
        .rst0_n(rst0_n),
        .fill_req(fill_req),
        .fill_addr(fill_addr),
        .fill_busy(fill_busy),
        .fill_done(fill_done),
        .crit_valid(crit_valid),
        .crit_word(crit_word),
        .pmem_read(pmem_read),
        .pmem_address(pmem_address),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp),
        .array_wmask(array_wmask),
        .array_addr(array_addr),
        .array_din(array_din)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    // Drives one whole fill; gaps[4k +: 4] idle cycles precede beat k.
    // Expected line, address and critical word come from the beat list.
    task automatic run_fill(input logic [31:0] addr,
                            input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3,
                            input logic [15:0] gaps, input bit poke_busy);
        logic [63:0]  d[4];
        logic [255:0] line;
        logic [31:0]  line_addr;
        logic [63:0]  tbeat;
        logic [31:0]  cw;
        logic [3:0]   exp_ctl;
        int           tgt;
        d[0] = b0; d[1] = b1; d[2] = b2; d[3] = b3;
        line      = {b3, b2, b1, b0};
        line_addr = addr & ~32'd31;
        tgt       = int'(addr[4:3]);
        tbeat     = d[tgt];
        cw        = addr[2] ? tbeat[63:32] : tbeat[31:0];

        fill_addr = addr;
        fill_req  = 1'b1;
        pmem_resp = 1'b0;
        step();
        fill_req  = poke_busy;
        fill_addr = poke_busy ? 32'h0000_2000 : addr;
        n_cmp++;
        if ({fill_busy, pmem_read, fill_done, crit_valid} !== 4'b1100 ||
            pmem_address !== line_addr) begin
            n_err++;
            $display("FAIL start ctl=%b addr=%h exp ctl=1100 addr=%h",
                     {fill_busy, pmem_read, fill_done, crit_valid},
                     pmem_address, line_addr);
        end
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
                pmem_resp  = 1'b0;
                pmem_rdata = {$urandom, $urandom};
                step();
                n_cmp++;
                if ({fill_busy, pmem_read, fill_done, crit_valid} !== 4'b1100 ||
                    pmem_address !== line_addr || array_wmask !== 32'h0) begin
                    n_err++;
                    $display("FAIL gap k=%0d ctl=%b addr=%h mask=%h exp 1100 %h 0",
                             k, {fill_busy, pmem_read, fill_done, crit_valid},
                             pmem_address, array_wmask, line_addr);
                end
            end
            pmem_resp  = 1'b1;
            pmem_rdata = d[k];
            step();
            if (k == 3) begin
                fill_req = 1'b0;
            end
            exp_ctl = {1'b1, k != 3, k == 3, k == tgt};
            n_cmp++;
            if ({fill_busy, pmem_read, fill_done, crit_valid} !== exp_ctl) begin
                n_err++;
                $display("FAIL beat k=%0d ctl=%b exp %b", k,
                         {fill_busy, pmem_read, fill_done, crit_valid}, exp_ctl);
            end
            if (k == tgt) begin
                n_cmp++;
                if (crit_word !== cw) begin
                    n_err++;
                    $display("FAIL crit_word got %h exp %h", crit_word, cw);
                end
            end
        end
        n_cmp++;
        if (array_wmask !== 32'hFFFF_FFFF || array_addr !== addr[8:5] ||
            array_din !== line) begin
            n_err++;
            $display("FAIL write mask=%h idx=%h din=%h exp idx=%h din=%h",
                     array_wmask, array_addr, array_din, addr[8:5], line);
        end
        pmem_resp = 1'b0;
        step();
        n_cmp++;
        if ({fill_busy, pmem_read, fill_done, crit_valid} !== 4'b0000 ||
            array_wmask !== 32'h0 || array_din !== 256'h0 ||
            array_addr !== 4'h0) begin
            n_err++;
            $display("FAIL idle_after ctl=%b mask=%h idx=%h exp all zero",
                     {fill_busy, pmem_read, fill_done, crit_valid},
                     array_wmask, array_addr);
        end
    endtask

    task automatic test_reset();
        rst0_n = 1'b0;
        repeat (2) @(posedge clk0);
        #1;
        n_cmp++;
        if ({fill_busy, fill_done, crit_valid, crit_word, pmem_read,
             pmem_address, array_wmask, array_addr, array_din} !== '0) begin
            n_err++;
            $display("FAIL reset busy=%b done=%b crit=%b read=%b mask=%h exp 0",
                     fill_busy, fill_done, crit_valid, pmem_read, array_wmask);
        end
        rst0_n = 1'b1;
        step();
        n_cmp++;
        if ({fill_busy, pmem_read, fill_done, crit_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release ctl=%b exp 0000",
                     {fill_busy, pmem_read, fill_done, crit_valid});
        end
    endtask

    task automatic test_basic_fill();
        run_fill(32'h0000_1234, {16{4'h1}}, {16{4'h2}}, {16{4'h3}},
                 {16{4'h4}}, 16'h0000, 1'b0);
    endtask

    task automatic test_crit_word();
        run_fill(32'h0000_003C, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                 64'h5555_6666_7777_8888, 64'hDEAD_BEEF_CAFE_F00D, 16'h0000, 1'b0);
    endtask

    task automatic test_gapped();
        // resp pattern 1,0,0,1,0,1,1
        run_fill(32'h0000_0A48, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, 16'h0120, 1'b0);
    endtask

    task automatic test_busy_reject();
        run_fill(32'h0000_5560, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, 16'h1011, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        fill_addr = 32'h0000_7788;
        fill_req  = 1'b1;
        step();
        fill_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {2{$urandom}};
            step();
        end
        pmem_resp = 1'b0;
        #2 rst0_n = 1'b0;
        #1;
        n_cmp++;
        if ({fill_busy, pmem_read, fill_done} !== 3'b000 ||
            array_wmask !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset busy=%b read=%b done=%b mask=%h exp 0",
                     fill_busy, pmem_read, fill_done, array_wmask);
        end
        step();
        rst0_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {2{$urandom}};
            step();
            n_cmp++;
            if ({fill_busy, pmem_read, fill_done, crit_valid} !== 4'b0000 ||
                array_wmask !== 32'h0) begin
                n_err++;
                $display("FAIL late_beat k=%0d ctl=%b mask=%h exp 0", k,
                         {fill_busy, pmem_read, fill_done, crit_valid}, array_wmask);
            end
        end
        pmem_resp = 1'b0;
        run_fill(32'h0000_7788, 64'hA0A0_A0A0_A0A0_A0A0, 64'hB1B1_B1B1_B1B1_B1B1,
                 64'hC2C2_C2C2_C2C2_C2C2, 64'hD3D3_D3D3_D3D3_D3D3, 16'h0201, 1'b0);
    endtask

    task automatic test_stray_resp();
        for (int k = 0; k < 3; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            step();
            n_cmp++;
            if ({fill_busy, fill_done, crit_valid, pmem_read,
                 pmem_address, array_wmask, array_addr, array_din} !== '0) begin
                n_err++;
                $display("FAIL stray k=%0d busy=%b done=%b crit=%b read=%b exp 0",
                         k, fill_busy, fill_done, crit_valid, pmem_read);
            end
        end
        pmem_resp = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] g;
        for (int n = 0; n < 20; n++) begin
            g = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
                 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
            run_fill($urandom, {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, {$urandom, $urandom}, g,
                     1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst0_n     = 1'b0;
        fill_req   = 1'b0;
        fill_addr  = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        test_reset();
        test_basic_fill();
        test_crit_word();
        test_gapped();
        test_busy_reject();
        test_reset_mid_burst();
        test_stray_resp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Upstream feeder for the icache data array.
- On a miss, fetches one 256-bit line from physical memory as a 4-beat 64-bit burst and assembles it.
- Writes the assembled line into the data array in a single full-mask write cycle.
- Forwards the missed 32-bit instruction word to the fetch stage as soon as its beat arrives.

Parameters:
- s_index, 4, set index width; array address width.
- s_offset, 5, byte-offset width; line is 2**s_offset = 32 bytes = 256 bits.
- beat_width, 64, memory burst beat width; beats per line = 256/beat_width = 4.

Ports:
- clk0  in  1  clock; all state updates on rising edge.
- rst0_n  in  1  reset, asynchronous, active-low; one clock; the polarity and synchronicity are fixed.
- fill_req  in  1  miss request from icache control; sampled only in IDLE.
- fill_addr  in  32  miss byte address.
- fill_busy  out  1  high in any state other than IDLE.
- fill_done  out  1  one-cycle pulse in the WRITE cycle.
- crit_valid  out  1  one-cycle pulse when the requested word is available.
- crit_word  out  32  requested instruction word; valid only with crit_valid.
- pmem_read  out  1  burst read request to memory.
- pmem_address  out  32  line-aligned burst address.
- pmem_rdata  in  64  burst beat data.
- pmem_resp  in  1  beat-valid strobe; beats arrive in ascending order.
- array_wmask  out  32  byte write mask to the data array.
- array_addr  out  s_index  set index for the array write.
- array_din  out  256  assembled line.

Behaviour:
- Reset (async assert, sync deassert):
  - State goes to IDLE; beat counter = 0; line buffer = 0; latched address = 0.
  - All outputs = 0.
- States:
  - IDLE: fill_req=1 -> latch fill_addr with bits [4:0] cleared, counter = 0, go to BURST. fill_req=0 -> stay in IDLE.
  - BURST: pmem_read=1 and pmem_address = latched line address throughout. Each cycle with pmem_resp=1 stores pmem_rdata into buffer bits [64*cnt +: 64] and increments cnt. The resp that makes cnt reach 4 transitions to WRITE; pmem_read drops in that next cycle.
  - WRITE: exactly one cycle. array_wmask = 32'hFFFFFFFF, array_addr = latched addr[8:5], array_din = buffer, fill_done=1. Next state is IDLE.
- Outside WRITE: array_wmask = 0, array_addr = 0, array_din = 0. The array must never see a partial write.
- Latency: req -> pmem_read next cycle. Last beat -> WRITE next cycle. Back-to-back fill_req can start the next burst in the cycle after WRITE.
- Critical word:
  - Target beat = addr[4:3]; word select = addr[2].
  - On the pmem_resp cycle where cnt == addr[4:3], the next cycle gives crit_valid=1 and crit_word = beat[32*addr[2] +: 32], registered.
  - Fires exactly once per fill, including when the target is beat 3; in that case it coincides with WRITE.
- pmem_resp in IDLE or WRITE is ignored; the buffer is unchanged.
- fill_req while busy is ignored, with no queueing. Control must hold or re-issue the request.
- pmem_resp gaps (resp=0 cycles) mid-burst: stay in BURST, counter holds, pmem_read stays high.
- Reset mid-burst: immediate return to IDLE, pmem_read=0, no array write, no fill_done. Late beats after reset release are ignored.
- Counter is 2 bits plus terminal detect; it never wraps into a 5th beat.

Test Plan:
- Basic fill: req addr 0x0000_1234, 4 consecutive beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> pmem_address = 0x0000_1220; WRITE with array_addr = 4'h1, array_din = {44..,33..,22..,11..}, wmask all ones, fill_done for 1 cycle.
- Critical word: addr 0x0000_003C (beat 3, upper word), beat 3 = 0xDEADBEEF_CAFEF00D -> crit_valid 1 cycle after the 4th resp, crit_word = 0xDEADBEEF, same cycle as fill_done.
- Gapped burst: resp pattern 1,0,0,1,0,1,1 -> exactly 4 beats captured in order; WRITE one cycle after the final resp; pmem_read high until then.
- Busy reject: second fill_req at 0x0000_2000 during BURST -> ignored; pmem_address stays at the first line; only one fill_done.
- Reset mid-burst: drop rst0_n after 2 beats -> pmem_read=0 asynchronously; no array write. A subsequent fill completes with fresh data and no stale beats.
- Stray resp: pmem_resp=1 while IDLE -> no state change, buffer unchanged, no outputs asserted.
